// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

  localparam int FQ_DEPTH_DEFAULT = 8;
  localparam int FQ_XLEN          = 32;
  localparam int INSTR_BYTES      = 4;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [31:0]        instr;
    logic               pred_taken;
    logic [FQ_XLEN-1:0] pred_target;
  } fetch_entry_t;

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - fetch queue entry array, two write ports and two combinational read ports
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_wr_en0,
  input  logic [PW-1:0] i_wr_idx0,
  input  fetch_entry_t  i_wr_data0,
  input  logic          i_wr_en1,
  input  logic [PW-1:0] i_wr_idx1,
  input  fetch_entry_t  i_wr_data1,
  input  logic [PW-1:0] i_rd_idx0,
  input  logic [PW-1:0] i_rd_idx1,
  output fetch_entry_t  o_rd_data0,
  output fetch_entry_t  o_rd_data1
);

  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_wr_en0) r_mem[i_wr_idx0] <= i_wr_data0;
      if (i_wr_en1) r_mem[i_wr_idx1] <= i_wr_data1;
    end
  end

  assign o_rd_data0 = r_mem[i_rd_idx0];
  assign o_rd_data1 = r_mem[i_rd_idx1];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue instruction fetch queue between PC stage and decode
// Optional same-cycle enqueue-to-dequeue bypass when FETCHQ_BYPASS_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN  = FQ_XLEN,
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            flush,
  input  logic            enq_valid,
  input  logic            enq_valid2,
  input  logic [XLEN-1:0] enq_pc,
  input  logic [31:0]     enq_instr1,
  input  logic [31:0]     enq_instr2,
  input  logic            enq_pred_taken1,
  input  logic            enq_pred_taken2,
  input  logic [XLEN-1:0] enq_pred_target1,
  input  logic [XLEN-1:0] enq_pred_target2,
  output logic            enq_ready,
  output logic            deq_valid1,
  output logic            deq_valid2,
  output logic [XLEN-1:0] deq_pc1,
  output logic [XLEN-1:0] deq_pc2,
  output logic [31:0]     deq_instr1,
  output logic [31:0]     deq_instr2,
  output logic            deq_pred_taken1,
  output logic            deq_pred_taken2,
  output logic [XLEN-1:0] deq_pred_target1,
  output logic [XLEN-1:0] deq_pred_target2,
  input  logic [1:0]      deq_count,
  output logic [CW-1:0]   count
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          w_fire, w_byp;
  logic [1:0]    w_enq_n, w_dc, w_deq_n, w_pop_n, w_wr_n;
  logic [CW-1:0] w_avail;
  fetch_entry_t  w_slot1, w_slot2, w_wr0, w_rd1, w_rd2, w_out1, w_out2;

  assign count     = r_count;
  assign enq_ready = (r_count <= CW'(DEPTH - 2));
  assign w_fire    = enq_valid && enq_ready && !flush;
  assign w_enq_n   = enq_valid2 ? 2'd2 : 2'd1;
  assign w_dc      = (deq_count > 2'd2) ? 2'd2 : deq_count;

`ifdef FETCHQ_BYPASS_EN
  assign w_byp = w_fire && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_slot1 = '{pc: enq_pc, instr: enq_instr1, pred_taken: enq_pred_taken1,
                     pred_target: enq_pred_target1};
  assign w_slot2 = '{pc: enq_pc + XLEN'(INSTR_BYTES), instr: enq_instr2,
                     pred_taken: enq_pred_taken2, pred_target: enq_pred_target2};

  // Bypassed entries are consumed straight off the inputs and never stored.
  always_comb begin
    w_avail = w_byp ? CW'(w_enq_n) : r_count;
    w_deq_n = (CW'(w_dc) < w_avail) ? w_dc : w_avail[1:0];
    w_pop_n = w_byp ? 2'd0 : w_deq_n;
    w_wr_n  = 2'd0;
    if (w_fire) w_wr_n = w_byp ? (w_enq_n - w_deq_n) : w_enq_n;
    w_wr0   = (w_byp && w_deq_n == 2'd1) ? w_slot2 : w_slot1;
  end

  always_ff @(posedge CLK) begin
    if (!reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop_n);
      r_tail  <= r_tail + PW'(w_wr_n);
      r_count <= r_count + CW'(w_wr_n) - CW'(w_pop_n);
    end
  end

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .i_clk      (CLK),
    .i_resetn   (reset),
    .i_wr_en0   (w_wr_n != 2'd0),
    .i_wr_idx0  (r_tail),
    .i_wr_data0 (w_wr0),
    .i_wr_en1   (w_wr_n == 2'd2),
    .i_wr_idx1  (r_tail + PTR_ONE),
    .i_wr_data1 (w_slot2),
    .i_rd_idx0  (r_head),
    .i_rd_idx1  (r_head + PTR_ONE),
    .o_rd_data0 (w_rd1),
    .o_rd_data1 (w_rd2)
  );

  always_comb begin
    w_out1     = w_rd1;
    w_out2     = w_rd2;
    deq_valid1 = (r_count >= CW'(1));
    deq_valid2 = (r_count >= CW'(2));
    if (w_byp) begin
      w_out1     = w_slot1;
      w_out2     = w_slot2;
      deq_valid1 = 1'b1;
      deq_valid2 = enq_valid2;
    end
  end

  assign deq_pc1          = w_out1.pc;
  assign deq_instr1       = w_out1.instr;
  assign deq_pred_taken1  = w_out1.pred_taken;
  assign deq_pred_target1 = w_out1.pred_target;
  assign deq_pc2          = w_out2.pc;
  assign deq_instr2       = w_out2.instr;
  assign deq_pred_taken2  = w_out2.pred_taken;
  assign deq_pred_target2 = w_out2.pred_target;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue with a FIFO scoreboard
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] IKEY = 32'h5A5A_0000;
  localparam logic [31:0] TOFS = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0, enq_valid2 = 1'b0;
  logic [31:0] enq_pc = '0, enq_instr1 = '0, enq_instr2 = '0;
  logic        enq_pred_taken1 = 1'b0, enq_pred_taken2 = 1'b0;
  logic [31:0] enq_pred_target1 = '0, enq_pred_target2 = '0;
  logic [1:0]  deq_count = '0;
  logic        enq_ready, deq_valid1, deq_valid2;
  logic [31:0] deq_pc1, deq_pc2, deq_instr1, deq_instr2;
  logic        deq_pred_taken1, deq_pred_taken2;
  logic [31:0] deq_pred_target1, deq_pred_target2;
  logic [CW-1:0] count;

  always #5 CLK = ~CLK;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_valid2(enq_valid2), .enq_pc(enq_pc),
    .enq_instr1(enq_instr1), .enq_instr2(enq_instr2),
    .enq_pred_taken1(enq_pred_taken1), .enq_pred_taken2(enq_pred_taken2),
    .enq_pred_target1(enq_pred_target1), .enq_pred_target2(enq_pred_target2),
    .enq_ready(enq_ready), .deq_valid1(deq_valid1), .deq_valid2(deq_valid2),
    .deq_pc1(deq_pc1), .deq_pc2(deq_pc2), .deq_instr1(deq_instr1), .deq_instr2(deq_instr2),
    .deq_pred_taken1(deq_pred_taken1), .deq_pred_taken2(deq_pred_taken2),
    .deq_pred_target1(deq_pred_target1), .deq_pred_target2(deq_pred_target2),
    .deq_count(deq_count), .count(count)
  );

  fetch_entry_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic fetch_entry_t mk(input logic [31:0] pc, input logic taken);
    mk = '{pc: pc, instr: pc ^ IKEY, pred_taken: taken, pred_target: pc + TOFS};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = sb.size();
    chk({tag, ".count"}, 64'(count), 64'(sz));
    chk({tag, ".enq_ready"}, 64'(enq_ready), 64'((DEPTH - sz) >= 2));
    chk({tag, ".deq_valid1"}, 64'(deq_valid1), 64'(sz >= 1));
    chk({tag, ".deq_valid2"}, 64'(deq_valid2), 64'(sz >= 2));
    if (sz >= 1) begin
      chk({tag, ".deq_pc1"}, 64'(deq_pc1), 64'(sb[0].pc));
      chk({tag, ".deq_instr1"}, 64'(deq_instr1), 64'(sb[0].instr));
      chk({tag, ".deq_taken1"}, 64'(deq_pred_taken1), 64'(sb[0].pred_taken));
      chk({tag, ".deq_target1"}, 64'(deq_pred_target1), 64'(sb[0].pred_target));
    end
    if (sz >= 2) begin
      chk({tag, ".deq_pc2"}, 64'(deq_pc2), 64'(sb[1].pc));
      chk({tag, ".deq_instr2"}, 64'(deq_instr2), 64'(sb[1].instr));
      chk({tag, ".deq_taken2"}, 64'(deq_pred_taken2), 64'(sb[1].pred_taken));
      chk({tag, ".deq_target2"}, 64'(deq_pred_target2), 64'(sb[1].pred_target));
    end
  endtask

  task automatic set_enq(input logic ev, input logic ev2, input logic [31:0] pc,
                         input logic t1, input logic t2);
    enq_valid        = ev;
    enq_valid2       = ev2;
    enq_pc           = pc;
    enq_instr1       = pc ^ IKEY;
    enq_instr2       = (pc + 32'd4) ^ IKEY;
    enq_pred_taken1  = t1;
    enq_pred_taken2  = t2;
    enq_pred_target1 = pc + TOFS;
    enq_pred_target2 = pc + 32'd4 + TOFS;
  endtask

  // One clock of traffic; the scoreboard is updated from what was driven, then the DUT is checked.
  task automatic step(input string tag, input logic fl, input logic ev, input logic ev2,
                      input logic [31:0] pc, input logic t1, input logic t2, input logic [1:0] dc);
    bit rdy;
    int n;
    flush     = fl;
    deq_count = dc;
    set_enq(ev, ev2, pc, t1, t2);
    rdy = (DEPTH - sb.size()) >= 2;
    @(posedge CLK);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      n = (int'(dc) > sb.size()) ? sb.size() : int'(dc);
      repeat (n) void'(sb.pop_front());
      if (ev && rdy) begin
        sb.push_back(mk(pc, t1));
        if (ev2) sb.push_back(mk(pc + 32'd4, t2));
      end
    end
    flush     = 1'b0;
    deq_count = 2'd0;
    set_enq(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_state(tag);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.enq_ready", 64'(enq_ready), 64'd1);
    chk("reset.deq_valid1", 64'(deq_valid1), 64'd0);
    chk("reset.deq_valid2", 64'(deq_valid2), 64'd0);
    chk("reset.deq_pc1", 64'(deq_pc1), 64'd0);
    reset = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);

    step("enq100", 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 2'd0);
    chk("enq100.pc1", 64'(deq_pc1), 64'h100);
    chk("enq100.pc2", 64'(deq_pc2), 64'h104);

    step("fill4", 1'b0, 1'b1, 1'b1, 32'h110, 1'b0, 1'b0, 2'd0);
    step("fill6", 1'b0, 1'b1, 1'b1, 32'h120, 1'b1, 1'b0, 2'd0);
    step("fill7", 1'b0, 1'b1, 1'b0, 32'h130, 1'b1, 1'b0, 2'd0);
    chk("fill7.enq_ready", 64'(enq_ready), 64'd0);
    step("full_ignore", 1'b0, 1'b1, 1'b1, 32'h140, 1'b0, 1'b0, 2'd0);
    chk("full_ignore.count", 64'(count), 64'd7);
    step("drain2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
    chk("drain2.count", 64'(count), 64'd5);
    chk("drain2.enq_ready", 64'(enq_ready), 64'd1);
    step("drain3", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
    step("drain1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
    step("over_deq", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2);
    chk("over_deq.count", 64'(count), 64'd0);

    step("wrap", 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 2'd0);
    chk("wrap.pc2", 64'(deq_pc2), 64'h204);
    chk("wrap.mem7", 64'(dut.u_storage.r_mem[7].pc), 64'h200);
    chk("wrap.mem0", 64'(dut.u_storage.r_mem[0].pc), 64'h204);

    for (int i = 0; i < 4; i++)
      step($sformatf("stream%0d", i), 1'b0, 1'b1, 1'b1, 32'h210 + 32'(i * 8),
           i[0], ~i[0], 2'd2);
    step("deq1_enq2", 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 2'd1);
    step("deq1_enq1", 1'b0, 1'b1, 1'b0, 32'h308, 1'b1, 1'b0, 2'd1);
    chk("deq1_enq1.count", 64'(count), 64'd3);
    step("pre_flush", 1'b0, 1'b1, 1'b0, 32'h30C, 1'b0, 1'b0, 2'd0);
    chk("pre_flush.count", 64'(count), 64'd4);
    step("flush", 1'b1, 1'b1, 1'b1, 32'h310, 1'b0, 1'b0, 2'd2);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.deq_valid1", 64'(deq_valid1), 64'd0);
    chk("flush.enq_ready", 64'(enq_ready), 64'd1);
    step("post_flush", 1'b0, 1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 2'd0);
    chk("post_flush.pc1", 64'(deq_pc1), 64'h400);
    chk("post_flush.mem0", 64'(dut.u_storage.r_mem[0].pc), 64'h400);

    step("pre_reset", 1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 2'd0);
    reset     = 1'b0;
    deq_count = 2'd1;
    set_enq(1'b1, 1'b1, 32'h600, 1'b1, 1'b1);
    @(posedge CLK);
    #1;
    reset     = 1'b1;
    deq_count = 2'd0;
    set_enq(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    sb.delete();
    check_state("mid_reset");
    chk("mid_reset.pc1", 64'(deq_pc1), 64'd0);
    chk("mid_reset.mem0", 64'(dut.u_storage.r_mem[0].pc), 64'd0);

`ifdef FETCHQ_BYPASS_EN
    deq_count = 2'd1;
    set_enq(1'b1, 1'b0, 32'h300, 1'b0, 1'b0);
    #1;
    chk("bypass.deq_valid1", 64'(deq_valid1), 64'd1);
    chk("bypass.deq_valid2", 64'(deq_valid2), 64'd0);
    chk("bypass.deq_pc1", 64'(deq_pc1), 64'h300);
    @(posedge CLK);
    #1;
    deq_count = 2'd0;
    set_enq(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("bypass.count", 64'(count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction fetch queue sitting directly downstream of the PC/branch-prediction stage. Each cycle it accepts one fetch group from the I-cache: base PC, up to two 32-bit instructions, and per-slot prediction info. It buffers individual instructions in a circular FIFO and presents up to two in program order to decode. It back-pressures the PC stage when fewer than two slots are free, and discards all contents on a mispredict flush.

## Interface
- XLEN, 32, address width
- DEPTH, 8, instruction slots; power of two, ≥4
- CLK  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- flush  in  1  mispredict flush; empties the queue
- enq_valid  in  1  fetch group present
- enq_valid2  in  1  second slot valid (0 when slot 1 is a predicted-taken control transfer)
- enq_pc  in  XLEN  PC of slot 1; slot 2 PC = enq_pc+4
- enq_instr1, enq_instr2  in  32  instructions
- enq_pred_taken1, enq_pred_taken2  in  1  predicted-taken flags
- enq_pred_target1, enq_pred_target2  in  XLEN  final predicted targets
- enq_ready  out  1  ≥2 free slots; PC stage holds while low
- deq_valid1, deq_valid2  out  1  head / head+1 entries valid
- deq_pc1, deq_pc2  out  XLEN
- deq_instr1, deq_instr2  out  32
- deq_pred_taken1, deq_pred_taken2  out  1
- deq_pred_target1, deq_pred_target2  out  XLEN
- deq_count  in  2  entries consumed by decode this cycle (0–2)
- count  out  $clog2(DEPTH)+1  occupied slots

## Operation
- Storage: DEPTH entries {pc, instr, pred_taken, pred_target}. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- Enqueue fires on enq_valid && enq_ready.
  - Slot 1 is written at tail.
  - Slot 2 is written at tail+1 only if enq_valid2.
  - tail advances by enq_n (1 or 2).
- enq_ready = (DEPTH − count) ≥ 2. It is derived from registered count only and has no combinational path from deq_count.
- Dequeue outputs read head and head+1 combinationally.
  - deq_valid1 = count≥1.
  - deq_valid2 = count≥2.
- deq_n = min(deq_count, count); the clamp makes deq_count beyond the valid count harmless. deq_count=2 with deq_valid2=0 consumes only one entry. head advances by deq_n.
- Simultaneous enqueue and dequeue: count_next = count + enq_n − deq_n. Full and empty can both be crossed in the same cycle.
- Pointer wrap: slot 2 written at index (DEPTH−1)+1 lands at index 0. The same applies to head+1 reads.
- Flush: next cycle head=tail=count=0. Enqueue and dequeue in the flush cycle are ignored. Storage is not cleared.
- Reset (reset=0) takes priority over flush and all traffic. It clears pointers, count and storage to 0.
- Reset values: count=0, enq_ready=1, deq_valid1=deq_valid2=0, all deq data outputs 0.

## Timing
- Without bypass, enqueue-to-dequeue latency is 1 cycle: data written at edge N is visible on deq_* after edge N.
- deq_count is sampled at the same edge as the write.
- Throughput is 2 instructions/cycle in and 2 out when sustained.
- Flush takes effect at the next edge: deq_valid1=0 and enq_ready=1 in the cycle after flush.
- Reset asserted mid-operation takes effect at the next edge, regardless of enq/deq activity.

## Configuration
- FETCHQ_BYPASS_EN defined:
  - When count==0 and an enqueue fires, deq_* are driven combinationally from the enq_* inputs in the same cycle. deq_valid2 = enq_valid2.
  - The deq_n bypassed entries are not written and tail advances only by enq_n − deq_n.
  - Bypass is suppressed when flush=1.
- FETCHQ_BYPASS_EN undefined: no input-to-output combinational path and latency is always 1 cycle.

## Structure
- Package fetch_pkg holds:
  - typedef fetch_entry_t (pc, instr, pred_taken, pred_target)
  - FQ_DEPTH_DEFAULT = 8
  - INSTR_BYTES = 4
- Sub-module fq_storage holds the DEPTH×fetch_entry_t register array. It has 2 write ports (tail, tail+1, with enables) and 2 combinational read ports (head, head+1). All pointer and count logic stays in fetch_queue.

## Test plan
- Reset then idle → count=0, enq_ready=1, deq_valid1/2=0, deq_pc1=0.
- Enqueue pc=0x100, two instrs, deq_count=0 → next cycle count=2, deq_pc1=0x100, deq_pc2=0x104.
- Fill to 7 with deq_count=0, DEPTH=8 → enq_ready=0 and enq_valid is ignored. Then deq_count=2 → count=5 and enq_ready=1 next cycle.
- Wrap-around: head=tail=7 with count=0, enqueue pc=0x200 with both slots → entries at indices 7 and 0. deq_pc2=0x204 next cycle.
- Simultaneous flush, enqueue and deq_count=2 at count=4 → count=0, deq_valid1=0, no new entries. The next enqueue appears at index 0.
- With FETCHQ_BYPASS_EN, empty queue, enqueue pc=0x300 with enq_valid2=0 and deq_count=1 → deq_valid1=1, deq_pc1=0x300 in the same cycle. count stays 0.
